// File: rtl/axis_line_buffer_4row_pkg.sv
// Shared definitions for the 4-row line buffer.
//   LB_LINES  : number of rotating line RAMs (one per output row)
//   row_idx_t : index of a line RAM / output row
//   lb_addr_w : line-RAM address width for a given maximum line length
package axis_line_buffer_4row_pkg;

  localparam int LB_LINES = 4;

  typedef logic [1:0] row_idx_t;

  function automatic int lb_addr_w(input int max_width);
    return (max_width > 1) ? $clog2(max_width) : 1;
  endfunction

endpackage

// File: rtl/axis_line_buffer_4row_ram.sv
// True-dual-port single-clock RAM with no-change read behaviour: a port's
// output register only updates on an enabled read, so with enables low (or
// while writing) the last read value is held.
//   LOW_LATENCY=1 : read data one cycle after the enabled read
//   LOW_LATENCY=0 : one extra output register stage
// Ports (A and B identical):
//   clk_i                 clock
//   en*_i / we*_i         port enable / write enable
//   addr*_i, din*_i       address and write data
//   dout*_o               read data
module axis_line_buffer_4row_ram #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter bit LOW_LATENCY = 1'b1
) (
  input  logic              clk_i,
  input  logic              ena_i,
  input  logic              wea_i,
  input  logic [ADDR_W-1:0] addra_i,
  input  logic [DATA_W-1:0] dina_i,
  output logic [DATA_W-1:0] douta_o,
  input  logic              enb_i,
  input  logic              web_i,
  input  logic [ADDR_W-1:0] addrb_i,
  input  logic [DATA_W-1:0] dinb_i,
  output logic [DATA_W-1:0] doutb_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] douta_q, doutb_q;

  always_ff @(posedge clk_i) begin
    if (ena_i && wea_i) mem[addra_i] <= dina_i;
    if (enb_i && web_i) mem[addrb_i] <= dinb_i;
  end

  always_ff @(posedge clk_i) begin
    if (ena_i && !wea_i) douta_q <= mem[addra_i];
    if (enb_i && !web_i) doutb_q <= mem[addrb_i];
  end

  if (LOW_LATENCY) begin : g_low_lat
    assign douta_o = douta_q;
    assign doutb_o = doutb_q;
  end else begin : g_reg_out
    logic [DATA_W-1:0] douta_r, doutb_r;
    always_ff @(posedge clk_i) begin
      douta_r <= douta_q;
      doutb_r <= doutb_q;
    end
    assign douta_o = douta_r;
    assign doutb_o = doutb_r;
  end

endmodule

// File: rtl/axis_line_buffer_4row.sv
// 4-row line buffer feeding the bicubic interpolator. Each accepted input
// pixel is written into the line RAM of the current line while the other
// three RAMs are read at the same column; one cycle later the 4-row column
// (rows y-3..y) is presented on the master stream.
// Optional build macro: LB_EDGE_REPLICATE_EN -- emit from the first line of a
// frame, replicating the oldest available line into missing upper rows.
// Ports:
//   clka, rsta                    clock, async active-high reset
//   s_axis_tdata/tvalid/tready    pixel input stream
//   s_axis_tuser / tlast          start of frame / end of line
//   m_axis_tdata                  {row y-3, row y-2, row y-1, row y}
//   m_axis_tvalid/tready          column output handshake
//   m_axis_tuser / tlast          first column of frame / last of line
//   overflow                      sticky over-long line flag, cleared by tuser
module axis_line_buffer_4row
  import axis_line_buffer_4row_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_WIDTH = 1024
) (
  input  logic                       clka,
  input  logic                       rsta,
  input  logic [DATA_W-1:0]          s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tuser,
  input  logic                       s_axis_tlast,
  output logic [LB_LINES*DATA_W-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tuser,
  output logic                       m_axis_tlast,
  output logic                       overflow
);

  localparam int AW = lb_addr_w(MAX_WIDTH);
  // x must be able to hold MAX_WIDTH itself (the over-long parking value)
  localparam int XW = AW + 1;

  logic [XW-1:0]     x_q, x_d;
  row_idx_t          wr_line_q, wr_line_d;
  logic [1:0]        filled_q, filled_d;
  logic              ovf_q, ovf_d;
  logic              sof_pend_q, sof_pend_d;
  logic              vld_q, vld_d;
  logic              user_q, user_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] pix_q, pix_d;
  row_idx_t          sel_q, sel_d;

  logic              in_acc, drop, keep, emit;
  row_idx_t          line_eff;
  logic [XW-1:0]     x_eff;
  logic [1:0]        fill_eff;

  logic [LB_LINES-1:0] ram_ena, ram_enb;
  logic [DATA_W-1:0]   rd_data      [LB_LINES];
  logic [DATA_W-1:0]   unused_douta [LB_LINES];

  assign s_axis_tready = !vld_q || m_axis_tready;
  assign in_acc        = s_axis_tvalid && s_axis_tready;

  // tuser restarts the frame before this pixel is placed, so it lands at
  // column 0 of line 0 even when it arrives mid-line.
  assign line_eff = s_axis_tuser ? row_idx_t'(0) : wr_line_q;
  assign x_eff    = s_axis_tuser ? '0 : x_q;
  assign fill_eff = s_axis_tuser ? 2'd0 : filled_q;

  assign drop = (x_eff == XW'(MAX_WIDTH));
  assign keep = in_acc && !drop;
`ifdef LB_EDGE_REPLICATE_EN
  assign emit = keep;
`else
  assign emit = keep && (fill_eff == 2'd3);
`endif

  always_comb begin
    x_d        = x_q;
    wr_line_d  = wr_line_q;
    filled_d   = filled_q;
    ovf_d      = ovf_q;
    sof_pend_d = sof_pend_q;
    vld_d      = vld_q;
    user_d     = user_q;
    last_d     = last_q;
    pix_d      = pix_q;
    sel_d      = sel_q;
    if (in_acc) begin
      x_d        = drop ? x_eff : x_eff + XW'(1);
      wr_line_d  = line_eff;
      filled_d   = fill_eff;
      ovf_d      = drop || (ovf_q && !s_axis_tuser);
      sof_pend_d = (s_axis_tuser || sof_pend_q) && !emit;
      if (s_axis_tlast) begin
        x_d       = '0;
        wr_line_d = line_eff + row_idx_t'(1);
        if (fill_eff != 2'd3) filled_d = fill_eff + 2'd1;
      end
      vld_d  = emit;
      user_d = emit && (s_axis_tuser || sof_pend_q);
      last_d = s_axis_tlast;
      pix_d  = s_axis_tdata;
      sel_d  = line_eff;
    end else if (m_axis_tready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      x_q        <= '0;
      wr_line_q  <= '0;
      filled_q   <= '0;
      ovf_q      <= 1'b0;
      sof_pend_q <= 1'b0;
      vld_q      <= 1'b0;
      user_q     <= 1'b0;
      last_q     <= 1'b0;
      pix_q      <= '0;
      sel_q      <= '0;
    end else begin
      x_q        <= x_d;
      wr_line_q  <= wr_line_d;
      filled_q   <= filled_d;
      ovf_q      <= ovf_d;
      sof_pend_q <= sof_pend_d;
      vld_q      <= vld_d;
      user_q     <= user_d;
      last_q     <= last_d;
      pix_q      <= pix_d;
      sel_q      <= sel_d;
    end
  end

  // Write the current line, read the other three. Dropped pixels and stalls
  // leave every enable low so RAM outputs (and thus m_axis_tdata) hold.
  always_comb begin
    for (int i = 0; i < LB_LINES; i++) begin
      ram_ena[i] = keep && (line_eff == row_idx_t'(i));
      ram_enb[i] = keep && (line_eff != row_idx_t'(i));
    end
  end

  for (genvar i = 0; i < LB_LINES; i++) begin : g_ram
    axis_line_buffer_4row_ram #(
      .DATA_W      (DATA_W),
      .DEPTH       (MAX_WIDTH),
      .ADDR_W      (AW),
      .LOW_LATENCY (1'b1)
    ) u_ram (
      .clk_i   (clka),
      .ena_i   (ram_ena[i]),
      .wea_i   (1'b1),
      .addra_i (x_eff[AW-1:0]),
      .dina_i  (s_axis_tdata),
      .douta_o (unused_douta[i]),
      .enb_i   (ram_enb[i]),
      .web_i   (1'b0),
      .addrb_i (x_eff[AW-1:0]),
      .dinb_i  ('0),
      .doutb_o (rd_data[i])
    );
  end

  // Row y-k lives in RAM (line - k) mod 4; 2-bit wrap does the modulo.
  row_idx_t          r1, r2, r3;
  logic [DATA_W-1:0] y0, y1, y2, y3;
  assign r1 = sel_q - row_idx_t'(1);
  assign r2 = sel_q - row_idx_t'(2);
  assign r3 = sel_q - row_idx_t'(3);

`ifdef LB_EDGE_REPLICATE_EN
  logic [1:0] fill1_q;
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta)        fill1_q <= '0;
    else if (in_acc) fill1_q <= fill_eff;
  end
`endif

  always_comb begin
    y0 = pix_q;
    y1 = rd_data[r1];
    y2 = rd_data[r2];
    y3 = rd_data[r3];
`ifdef LB_EDGE_REPLICATE_EN
    // rows above the top of the frame repeat the oldest line of the frame
    case (fill1_q)
      2'd0: begin y1 = y0; y2 = y0; y3 = y0; end
      2'd1: begin y2 = y1; y3 = y1; end
      2'd2: y3 = y2;
      default: ;
    endcase
`endif
  end

  assign m_axis_tdata  = {y3, y2, y1, y0};
  assign m_axis_tvalid = vld_q;
  assign m_axis_tuser  = user_q;
  assign m_axis_tlast  = last_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_axis_line_buffer_4row.sv
`timescale 1ns/1ps
module tb_axis_line_buffer_4row;
  localparam int DW = 8;
  localparam int MW = 16;
`ifdef LB_EDGE_REPLICATE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  logic          clka = 1'b0, rsta = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
  logic          s_tready;
  logic [4*DW-1:0] m_tdata;
  logic          m_tvalid, m_tuser, m_tlast, overflow;
  logic          m_tready = 1'b1;

  axis_line_buffer_4row #(.DATA_W(DW), .MAX_WIDTH(MW)) dut (
    .clka          (clka),
    .rsta          (rsta),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .overflow      (overflow)
  );

  always #5 clka = ~clka;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: the frame as a picture, img[line][x]; a column is the
  // pixel at x of lines y, y-1, y-2, y-3 (clamped to line 0 when replicating).
  typedef struct packed {
    logic [4*DW-1:0] data;
    logic            user;
    logic            last;
  } col_t;

  col_t          expq[$];
  col_t          out_log[$];
  logic [DW-1:0] img [8][MW];
  int            m_line = 0, m_x = 0;
  bit            m_ovf = 0, m_sof = 0;
  bit            rnd_ready = 0;
  bit            prev_stall = 0;
  logic [4*DW-1:0] prev_data;

  task automatic model_accept(input logic [DW-1:0] d, input bit u, input bit l);
    col_t c;
    if (u) begin m_line = 0; m_x = 0; m_ovf = 0; m_sof = 1; end
    if (m_x >= MW) m_ovf = 1;
    else begin
      img[m_line % 8][m_x] = d;
      if (m_line >= 3 || REPL) begin
        for (int k = 0; k < 4; k++) begin
          int src;
          src = m_line - k;
          if (src < 0) src = 0;
          c.data[k*DW +: DW] = img[src % 8][m_x];
        end
        c.user = m_sof;
        c.last = l;
        m_sof  = 0;
        expq.push_back(c);
      end
      m_x++;
    end
    if (l) begin m_line++; m_x = 0; end
  endtask

  // Monitor: outputs are stable at the falling edge; handshakes seen here are
  // the ones that complete at the next rising edge.
  always @(negedge clka) begin
    if (rsta) begin
      expq.delete();
      m_line = 0; m_x = 0; m_ovf = 0; m_sof = 0; prev_stall = 0;
    end else begin
      chk("vld", m_tvalid, expq.size() != 0);
      chk("ovf", overflow, m_ovf);
      chk("s_rdy", s_tready, expq.size() == 0 || m_tready);
      if (m_tvalid && expq.size() != 0) begin
        chk("data", m_tdata, expq[0].data);
        chk("user", m_tuser, expq[0].user);
        chk("last", m_tlast, expq[0].last);
      end
      if (prev_stall) chk("stall", m_tdata, prev_data);
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      if (m_tvalid && m_tready) begin
        out_log.push_back('{data: m_tdata, user: m_tuser, last: m_tlast});
        if (expq.size() != 0) void'(expq.pop_front());
      end
      if (s_tvalid && s_tready) model_accept(s_tdata, s_tuser, s_tlast);
    end
  end

  always @(posedge clka) begin
    #1;
    if (rnd_ready) m_tready = 1'($urandom_range(0, 1));
  end

  // Called and returns at 1 ns after a rising edge.
  task automatic send_px(input logic [DW-1:0] d, input bit u, input bit l);
    bit acc = 0;
    int n = 0;
    s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clka); acc = s_tready;
      @(posedge clka); #1; n++;
    end
    if (!acc) chk("acc_timeout", 0, 1);
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clka);
    #1;
  endtask

  task automatic run_s1(input string tag);
    out_log.delete();
    for (int ln = 0; ln < 4; ln++)
      for (int x = 0; x < 8; x++)
        send_px(8'(16*ln + x), ln == 0 && x == 0, x == 7);
    idle(3);
`ifdef LB_EDGE_REPLICATE_EN
    chk({tag, "_cnt"}, out_log.size(), 32);
    chk({tag, "_l0x2"}, out_log[2].data, 32'h02020202);
    chk({tag, "_l1x2"}, out_log[10].data, 32'h02020212);
    chk({tag, "_user"}, out_log[0].user, 1);
    chk({tag, "_end"}, out_log[31].data, 32'h07172737);
    chk({tag, "_tlast"}, out_log[31].last, 1);
`else
    chk({tag, "_cnt"}, out_log.size(), 8);
    chk({tag, "_first"}, out_log[0].data, 32'h00102030);
    chk({tag, "_user"}, out_log[0].user, 1);
    chk({tag, "_end"}, out_log[7].data, 32'h07172737);
    chk({tag, "_tlast"}, out_log[7].last, 1);
`endif
  endtask

  localparam int RND_CNT  = REPL ? 96 : 48;
  localparam int MID_CNT  = REPL ? 101 : 16;
  localparam int OVF_CNT  = REPL ? 64 : 16;

  initial begin
    repeat (2) @(posedge clka);
    #1;
    chk("rst_mvld", m_tvalid, 0);
    chk("rst_muser", m_tuser, 0);
    chk("rst_mlast", m_tlast, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_srdy", s_tready, 1);
    rsta = 1'b0;
    idle(1);

    run_s1("s1");

    // random data, random backpressure, random input gaps, lines at MAX_WIDTH
    out_log.delete();
    rnd_ready = 1;
    for (int ln = 0; ln < 6; ln++)
      for (int x = 0; x < 16; x++) begin
        send_px(8'($urandom), ln == 0 && x == 0, x == 15);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    idle(30);
    rnd_ready = 0;
    m_tready  = 1'b1;
    idle(3);
    chk("rnd_cnt", out_log.size(), RND_CNT);

    // new frame starting mid-line (line 2, x=5)
    out_log.delete();
    for (int ln = 0; ln < 2; ln++)
      for (int x = 0; x < 16; x++) send_px(8'($urandom), ln == 0 && x == 0, x == 15);
    for (int x = 0; x < 5; x++) send_px(8'($urandom), 0, 0);
    for (int ln = 0; ln < 4; ln++)
      for (int x = 0; x < 16; x++) send_px(8'($urandom), ln == 0 && x == 0, x == 15);
    idle(3);
    chk("mid_cnt", out_log.size(), MID_CNT);
    chk("mid_user", out_log[0].user, 1);

    // over-long line: 18 pixels with MAX_WIDTH=16
    out_log.delete();
    for (int ln = 0; ln < 3; ln++)
      for (int x = 0; x < 16; x++) send_px(8'($urandom), ln == 0 && x == 0, x == 15);
    chk("ovf_pre", overflow, 0);
    for (int x = 0; x < 18; x++) send_px(8'($urandom), 0, x == 17);
    idle(2);
    chk("ovf_set", overflow, 1);
    chk("ovf_cnt", out_log.size(), OVF_CNT);
    send_px(8'h55, 1, 0);
    idle(1);
    chk("ovf_clr", overflow, 0);

    // async reset while a column is stalled on the output
    for (int ln = 0; ln < 4; ln++)
      for (int x = 0; x < 8; x++)
        if (ln < 3 || x < 3) send_px(8'(16*ln + x), ln == 0 && x == 0, x == 7);
    m_tready = 1'b0;
    idle(1);
    chk("pre_rst_vld", m_tvalid, 1);
    chk("pre_rst_rdy", s_tready, 0);
    s_tdata = 8'h33; s_tvalid = 1'b1;
    #1 rsta = 1'b1;
    #1;
    chk("arst_vld", m_tvalid, 0);
    chk("arst_rdy", s_tready, 1);
    s_tvalid = 1'b0;
    repeat (2) @(posedge clka);
    #1;
    rsta = 1'b0;
    m_tready = 1'b1;
    idle(1);
    run_s1("s1r");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
